// File: rtl/branch_resolution_unit.sv
// Carries each fetch-stage prediction through the D and E registers, resolves it in E and
// drives the predictor's training interface. Define BRANCH_STATS_EN for branch/mispredict counters.
module branch_resolution_unit #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             stall_d_i,
  input  logic             flush_d_i,
  input  logic             flush_e_i,
  input  logic             pc_src_pred_f_i,
  input  logic [WIDTH-1:0] pred_target_f_i,
  input  logic [WIDTH-1:0] pc_plus4_f_i,
  input  logic             branch_e_i,
  input  logic             pc_src_res_e_i,
  input  logic [WIDTH-1:0] target_e_i,
  output logic             pc_src_pred_e_o,
  output logic             mispredict_e_o,
  output logic [WIDTH-1:0] redirect_pc_o,
  output logic             update_en_o,
  output logic             update_taken_o
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] branch_cnt_o,
  output logic [CNT_WIDTH-1:0] mispredict_cnt_o
`endif
);

  if (WIDTH < 1 || CNT_WIDTH < 1) begin : g_param_check
    $error("branch_resolution_unit: WIDTH and CNT_WIDTH must be at least 1");
  end

  logic             valid_d;
  logic             pred_d;
  logic [WIDTH-1:0] pred_target_d;
  logic [WIDTH-1:0] pc_plus4_d;

  logic             valid_e;
  logic             pred_e;
  logic [WIDTH-1:0] pred_target_e;
  logic [WIDTH-1:0] pc_plus4_e;

  logic kill;
  logic valid_br_e;
  logic dir_miss;
  logic tgt_miss;

  // A mispredict squashes both younger wrong-path slots, even when D is stalled.
  assign kill = mispredict_e_o;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_d       <= 1'b0;
      pred_d        <= 1'b0;
      pred_target_d <= '0;
      pc_plus4_d    <= '0;
    end else if (kill || flush_d_i) begin
      valid_d       <= 1'b0;
      pred_d        <= 1'b0;
      pred_target_d <= '0;
      pc_plus4_d    <= '0;
    end else if (!stall_d_i) begin
      valid_d       <= 1'b1;
      pred_d        <= pc_src_pred_f_i;
      pred_target_d <= pred_target_f_i;
      pc_plus4_d    <= pc_plus4_f_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_e       <= 1'b0;
      pred_e        <= 1'b0;
      pred_target_e <= '0;
      pc_plus4_e    <= '0;
    end else if (kill || flush_e_i) begin
      valid_e       <= 1'b0;
      pred_e        <= 1'b0;
      pred_target_e <= '0;
      pc_plus4_e    <= '0;
    end else begin
      valid_e       <= valid_d;
      pred_e        <= pred_d;
      pred_target_e <= pred_target_d;
      pc_plus4_e    <= pc_plus4_d;
    end
  end

  always_comb begin
    valid_br_e = valid_e & branch_e_i;
    dir_miss   = pred_e ^ pc_src_res_e_i;
    // Both taken but to different places still needs a redirect.
    tgt_miss   = pred_e & pc_src_res_e_i & (pred_target_e != target_e_i);
  end

  // Outputs fed straight from E-stage inputs are held at 0 while reset is asserted.
  assign mispredict_e_o  = valid_br_e & (dir_miss | tgt_miss);
  assign redirect_pc_o   = reset_i ? '0 : (pc_src_res_e_i ? target_e_i : pc_plus4_e);
  assign update_en_o     = valid_br_e;
  assign update_taken_o  = pc_src_res_e_i & ~reset_i;
  assign pc_src_pred_e_o = pred_e & valid_e;

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      branch_cnt_o     <= '0;
      mispredict_cnt_o <= '0;
    end else begin
      if (update_en_o && (branch_cnt_o != '1)) begin
        branch_cnt_o <= branch_cnt_o + CNT_WIDTH'(1);
      end
      if (mispredict_e_o && (mispredict_cnt_o != '1)) begin
        mispredict_cnt_o <= mispredict_cnt_o + CNT_WIDTH'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Bench for branch_resolution_unit: vector table through the F->D->E pipe with a result
// queue, plus hand sequences for stall/flush/kill priority, async reset and optional counters.
module tb_branch_resolution_unit;
  localparam int WIDTH = 32;
`ifdef BRANCH_STATS_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 32;
`endif
  localparam int W = WIDTH + 4;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic             stall_d_i, flush_d_i, flush_e_i;
  logic             pc_src_pred_f_i;
  logic [WIDTH-1:0] pred_target_f_i, pc_plus4_f_i;
  logic             branch_e_i, pc_src_res_e_i;
  logic [WIDTH-1:0] target_e_i;
  logic             pc_src_pred_e_o, mispredict_e_o, update_en_o, update_taken_o;
  logic [WIDTH-1:0] redirect_pc_o;
`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] branch_cnt_o, mispredict_cnt_o;
`endif

  branch_resolution_unit #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_W)) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .stall_d_i       (stall_d_i),
    .flush_d_i       (flush_d_i),
    .flush_e_i       (flush_e_i),
    .pc_src_pred_f_i (pc_src_pred_f_i),
    .pred_target_f_i (pred_target_f_i),
    .pc_plus4_f_i    (pc_plus4_f_i),
    .branch_e_i      (branch_e_i),
    .pc_src_res_e_i  (pc_src_res_e_i),
    .target_e_i      (target_e_i),
    .pc_src_pred_e_o (pc_src_pred_e_o),
    .mispredict_e_o  (mispredict_e_o),
    .redirect_pc_o   (redirect_pc_o),
    .update_en_o     (update_en_o),
    .update_taken_o  (update_taken_o)
`ifdef BRANCH_STATS_EN
    ,
    .branch_cnt_o    (branch_cnt_o),
    .mispredict_cnt_o(mispredict_cnt_o)
`endif
  );

  typedef struct {
    logic             br;
    logic             pred;
    logic [WIDTH-1:0] pred_tgt;
    logic [WIDTH-1:0] pc4;
    logic             res;
    logic [WIDTH-1:0] tgt_e;
    logic             exp_mis;
    logic [WIDTH-1:0] exp_redir;
    logic             exp_en;
    logic             exp_tk;
  } vec_t;

  vec_t             tbl[8];
  logic [W-1:0]     exp_q[$];
  int               checks = 0;
  int               errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    stall_d_i       = 1'b0;
    flush_d_i       = 1'b0;
    flush_e_i       = 1'b0;
    pc_src_pred_f_i = 1'b0;
    pred_target_f_i = '0;
    pc_plus4_f_i    = '0;
    branch_e_i      = 1'b0;
    pc_src_res_e_i  = 1'b0;
    target_e_i      = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
  endtask

  // Empties D and E by flushing two bubbles through.
  task automatic drain();
    idle_inputs();
    flush_d_i = 1'b1;
    tick();
    tick();
    flush_d_i = 1'b0;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t model(input logic br, input logic pred, input logic [WIDTH-1:0] pred_tgt,
                                 input logic [WIDTH-1:0] pc4, input logic res,
                                 input logic [WIDTH-1:0] tgt_e);
    vec_t v;
    v.br        = br;
    v.pred      = pred;
    v.pred_tgt  = pred_tgt;
    v.pc4       = pc4;
    v.res       = res;
    v.tgt_e     = tgt_e;
    v.exp_mis   = br & ((pred != res) | (pred & res & (pred_tgt != tgt_e)));
    v.exp_redir = res ? tgt_e : pc4;
    v.exp_en    = br;
    v.exp_tk    = res;
    return v;
  endfunction

  task automatic compare_head();
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: result seen with no expected entry at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      check("pred_e", WIDTH'(pc_src_pred_e_o), WIDTH'(e[W-1]));
      check("mispredict", WIDTH'(mispredict_e_o), WIDTH'(e[W-2]));
      check("update_en", WIDTH'(update_en_o), WIDTH'(e[W-3]));
      check("update_taken", WIDTH'(update_taken_o), WIDTH'(e[W-4]));
      check("redirect_pc", redirect_pc_o, e[WIDTH-1:0]);
    end
  endtask

  // ---------------- driver ----------------
  // F -> D, bubble behind it, then resolve in E; D/E hold only bubbles afterwards.
  task automatic run_vec(input vec_t v);
    pc_src_pred_f_i = v.pred;
    pred_target_f_i = v.pred_tgt;
    pc_plus4_f_i    = v.pc4;
    flush_d_i       = 1'b0;
    branch_e_i      = 1'b0;
    exp_q.push_back({v.pred, v.exp_mis, v.exp_en, v.exp_tk, v.exp_redir});
    tick();
    flush_d_i       = 1'b1;
    pc_src_pred_f_i = ~v.pred;
    tick();
    branch_e_i      = v.br;
    pc_src_res_e_i  = v.res;
    target_e_i      = v.tgt_e;
    @(negedge clk_i);
    compare_head();
    tick();
    branch_e_i      = 1'b0;
    flush_d_i       = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t v;
    tbl[0] = '{1'b1, 1'b1, 32'h100, 32'h104, 1'b1, 32'h100, 1'b0, 32'h100, 1'b1, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 32'h000, 32'h204, 1'b1, 32'h300, 1'b1, 32'h300, 1'b1, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 32'h400, 32'h404, 1'b1, 32'h440, 1'b1, 32'h440, 1'b1, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 32'h500, 32'h20C, 1'b0, 32'h500, 1'b1, 32'h20C, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 32'h600, 32'h604, 1'b0, 32'h700, 1'b0, 32'h604, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 32'h800, 32'h804, 1'b0, 32'h900, 1'b0, 32'h804, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 32'hA00, 32'hA04, 1'b1, 32'hB00, 1'b0, 32'hB00, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 32'hC00, 32'hC04, 1'b0, 32'hD00, 1'b0, 32'hC04, 1'b1, 1'b0};

    // Reset with live-looking E inputs: every output must read 0.
    idle_inputs();
    branch_e_i     = 1'b1;
    pc_src_res_e_i = 1'b1;
    target_e_i     = 32'hABC;
    reset_i        = 1'b1;
    @(negedge clk_i);
    check("rst_pred_e", WIDTH'(pc_src_pred_e_o), '0);
    check("rst_mispredict", WIDTH'(mispredict_e_o), '0);
    check("rst_redirect", redirect_pc_o, '0);
    check("rst_update_en", WIDTH'(update_en_o), '0);
    check("rst_update_taken", WIDTH'(update_taken_o), '0);
`ifdef BRANCH_STATS_EN
    check("rst_branch_cnt", WIDTH'(branch_cnt_o), '0);
    check("rst_mispredict_cnt", WIDTH'(mispredict_cnt_o), '0);
`endif
    tick();
    reset_i = 1'b0;
    drain();

    for (int i = 0; i < 8; i++) run_vec(tbl[i]);
    for (int i = 0; i < 8; i++) begin
      v = model(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), WIDTH'($urandom_range(0, 3)) << 4,
                WIDTH'($urandom_range(16, 4095)) << 2, 1'($urandom_range(0, 1)),
                WIDTH'($urandom_range(0, 3)) << 4);
      run_vec(v);
    end

    // Stall while the prediction waits in F: three extra cycles before it reaches E.
    drain();
    pc_src_pred_f_i = 1'b1;
    pred_target_f_i = 32'h100;
    pc_plus4_f_i    = 32'h104;
    stall_d_i       = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk_i);
      check("stall_pred_e_hidden", WIDTH'(pc_src_pred_e_o), '0);
    end
    stall_d_i = 1'b0;
    tick();
    @(negedge clk_i);
    check("stall_pred_e_in_d", WIDTH'(pc_src_pred_e_o), '0);
    flush_d_i = 1'b1;
    tick();
    @(negedge clk_i);
    check("stall_pred_e_arrives", WIDTH'(pc_src_pred_e_o), 1);

    // Direction mispredict with D stalled: kill must still clear D and E.
    drain();
    pc_src_pred_f_i = 1'b0;
    pc_plus4_f_i    = 32'h204;
    tick();
    pc_src_pred_f_i = 1'b1;
    pred_target_f_i = 32'h500;
    pc_plus4_f_i    = 32'h504;
    tick();
    stall_d_i      = 1'b1;
    branch_e_i     = 1'b1;
    pc_src_res_e_i = 1'b1;
    target_e_i     = 32'h300;
    @(negedge clk_i);
    check("dir_mis_mispredict", WIDTH'(mispredict_e_o), 1);
    check("dir_mis_redirect", redirect_pc_o, 32'h300);
    tick();
    stall_d_i = 1'b0;
    @(negedge clk_i);
    check("kill_e_update_en", WIDTH'(update_en_o), '0);
    check("kill_e_pred_e", WIDTH'(pc_src_pred_e_o), '0);
    tick();
    @(negedge clk_i);
    check("kill_d_update_en", WIDTH'(update_en_o), '0);
    check("kill_d_pred_e", WIDTH'(pc_src_pred_e_o), '0);

    // flush_e_i turns the incoming instruction into a bubble.
    drain();
    pc_src_pred_f_i = 1'b1;
    pred_target_f_i = 32'hA00;
    tick();
    flush_d_i = 1'b1;
    flush_e_i = 1'b1;
    tick();
    flush_e_i      = 1'b0;
    branch_e_i     = 1'b1;
    pc_src_res_e_i = 1'b1;
    target_e_i     = 32'hA00;
    @(negedge clk_i);
    check("flush_e_update_en", WIDTH'(update_en_o), '0);
    check("flush_e_pred_e", WIDTH'(pc_src_pred_e_o), '0);
    check("flush_e_mispredict", WIDTH'(mispredict_e_o), '0);

    // Asynchronous reset between edges with a valid branch in E.
    drain();
    pc_src_pred_f_i = 1'b1;
    pred_target_f_i = 32'h900;
    pc_plus4_f_i    = 32'h904;
    tick();
    flush_d_i = 1'b1;
    tick();
    flush_d_i      = 1'b0;
    branch_e_i     = 1'b1;
    pc_src_res_e_i = 1'b1;
    target_e_i     = 32'h980;
    @(negedge clk_i);
    check("pre_rst_update_en", WIDTH'(update_en_o), 1);
    #2 reset_i = 1'b1;
    #1;
    check("async_rst_pred_e", WIDTH'(pc_src_pred_e_o), '0);
    check("async_rst_mispredict", WIDTH'(mispredict_e_o), '0);
    check("async_rst_redirect", redirect_pc_o, '0);
    check("async_rst_update_en", WIDTH'(update_en_o), '0);
    check("async_rst_update_taken", WIDTH'(update_taken_o), '0);
    tick();
    reset_i = 1'b0;
    @(negedge clk_i);
    check("post_rst_update_en_0", WIDTH'(update_en_o), '0);
    tick();
    @(negedge clk_i);
    check("post_rst_update_en_1", WIDTH'(update_en_o), '0);
    check("post_rst_mispredict", WIDTH'(mispredict_e_o), '0);

`ifdef BRANCH_STATS_EN
    do_reset();
    drain();
    for (int i = 0; i < 10; i++) begin
      v = model(1'b1, 1'b1, WIDTH'(32'h1000 + i * 16), WIDTH'(32'h2000 + i * 4), 1'b1,
                WIDTH'(32'h1000 + i * 16 + ((i < 3) ? 4 : 0)));
      run_vec(v);
    end
    @(negedge clk_i);
    check("branch_cnt_10", WIDTH'(branch_cnt_o), 10);
    check("mispredict_cnt_3", WIDTH'(mispredict_cnt_o), 3);
    for (int i = 0; i < 10; i++) begin
      v = model(1'b1, 1'b0, '0, WIDTH'(32'h3000 + i * 4), 1'b0, WIDTH'(32'h4000));
      run_vec(v);
    end
    @(negedge clk_i);
    check("branch_cnt_sat", WIDTH'(branch_cnt_o), 15);
    check("mispredict_cnt_hold", WIDTH'(mispredict_cnt_o), 3);
`endif

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
